// File: rtl/i2c_target_regport.sv
// i2c_target_regport
// ------------------
// I2C target engine with a byte-wide register port. The controller addresses
// the target, writes a register pointer, then either streams write bytes or
// issues a repeated START and streams read bytes. The pointer auto-increments
// and wraps at NUM_REGS-1. SCL/SDA are oversampled on clk; SCL is never
// stretched.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   scl          I2C clock input
//   sda          I2C data, open-drain (driven low or released to 'z)
//   o_wr_valid   one-cycle strobe with o_wr_addr / o_wr_data
//   o_rd_addr    current register pointer; i_rd_data returns that register
//   i_rd_data    read data for o_rd_addr
//   o_busy       high from address match until STOP or START
//   o_stop       one-cycle pulse on a STOP that ends an addressed transaction
module i2c_target_regport #(
  parameter logic [6:0]  ADDRESS     = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned PTR_W       = $clog2(NUM_REGS),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  inout  wire              sda,
  output logic             o_wr_valid,
  output logic [PTR_W-1:0] o_wr_addr,
  output logic [7:0]       o_wr_data,
  output logic [PTR_W-1:0] o_rd_addr,
  input  logic [7:0]       i_rd_data,
  output logic             o_busy,
  output logic             o_stop
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REGS - 1);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             stop_q, stop_d;

  logic             scl_s, sda_s;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]       shift_in;
  logic [PTR_W-1:0] ptr_inc;

  // Synchronisers shift in at the low end; the top stage is the clean copy.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // Bus conditions need SCL high both before and after the SDA edge.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};
  assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    stop_d     = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = busy_q;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: begin
        end
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDRESS) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // A read starts on the fall ending the ACK: bit 7 goes out at once
        // and the remaining bits sit left-aligned in the shift register.
        ADDR_ACK, RDATA_ACK: begin
          if (state_q == RDATA_ACK && scl_rise && sda_s) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            if (state_q == RDATA_ACK || rw_q) begin
              state_d   = RDATA;
              shift_d   = {i_rd_data[6:0], 1'b0};
              sda_oe_d  = ~i_rd_data[7];
              bit_cnt_d = 4'd1;
              ptr_d     = ptr_inc;
            end else begin
              state_d   = PTR;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end
        end
        PTR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (32'(shift_q) < NUM_REGS) begin
              state_d  = PTR_ACK;
              ptr_d    = shift_q[PTR_W-1:0];
              sda_oe_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = WDATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_in;
              ptr_d      = ptr_inc;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = WDATA_ACK;
            sda_oe_d = 1'b1;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchroniser flops reset to 1 so the idle bus shows no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      stop_q     <= stop_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd_addr  = ptr_q;
  assign o_busy     = busy_q;
  assign o_stop     = stop_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Testbench for i2c_target_regport: a bit-banged I2C controller drives the
// target while a transaction-level model (pointer plus expected write list)
// predicts acknowledgements, write strobes, read bytes and the final pointer.
module tb_i2c_target_regport;
  localparam logic [6:0] ADDRESS  = 7'h50;
  localparam int         NUM_REGS = 16;
  localparam int         PTR_W    = $clog2(NUM_REGS);
  localparam int         QTR      = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scl;
  logic             ctl_low;
  wire              sda;
  logic             o_wr_valid;
  logic [PTR_W-1:0] o_wr_addr;
  logic [7:0]       o_wr_data;
  logic [PTR_W-1:0] o_rd_addr;
  logic [7:0]       i_rd_data;
  logic             o_busy;
  logic             o_stop;

  logic [7:0] rd_mem [NUM_REGS];
  logic [7:0] tx_data [$];
  int         exp_addr [$];
  int         exp_data [$];
  int         seen_addr [$];
  int         seen_data [$];
  int         model_ptr;
  int         stop_count;
  bit         dut_low_seen;
  int         compared;
  int         mismatched;

  pullup (sda);
  assign sda       = ctl_low ? 1'b0 : 1'bz;
  assign i_rd_data = rd_mem[o_rd_addr];

  i2c_target_regport #(
    .ADDRESS(ADDRESS), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_busy(o_busy), .o_stop(o_stop)
  );

  always #5 clk = ~clk;

  // Record every write strobe and stop pulse, and any time the target pulls
  // SDA low while the controller has it released.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_valid) begin
        seen_addr.push_back(int'(o_wr_addr));
        seen_data.push_back(int'(o_wr_data));
      end
      if (o_stop) stop_count++;
      if (!ctl_low && sda == 1'b0) dut_low_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_q();
    repeat (QTR) @(posedge clk);
    #2;
  endtask

  task automatic bus_start();
    ctl_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    ctl_low = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic bus_stop();
    ctl_low = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    ctl_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    ctl_low = ~b; wait_q();
    scl = 1'b1;   wait_q();
    wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic recv_bit(output logic b);
    ctl_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    b = sda;        wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(nack);
  endtask

  // START, address byte, pointer byte, the bytes in tx_data, STOP.
  task automatic applyStimulus(input logic [7:0] addr_byte, input logic [7:0] ptr_byte,
                               input string tag);
    logic ack;
    bit   match;
    bit   ptr_ok;
    match  = (addr_byte[7:1] == ADDRESS) && !addr_byte[0];
    ptr_ok = match && (int'(ptr_byte) < NUM_REGS);
    seen_addr.delete(); seen_data.delete();
    exp_addr.delete();  exp_data.delete();
    stop_count = 0; dut_low_seen = 1'b0;
    bus_start();
    write_byte(addr_byte, ack);
    checkOutput({tag, ".addr_ack"}, int'(ack), match ? 0 : 1);
    checkOutput({tag, ".busy"}, int'(o_busy), match ? 1 : 0);
    write_byte(ptr_byte, ack);
    checkOutput({tag, ".ptr_ack"}, int'(ack), ptr_ok ? 0 : 1);
    if (ptr_ok) model_ptr = int'(ptr_byte);
    foreach (tx_data[i]) begin
      write_byte(tx_data[i], ack);
      checkOutput($sformatf("%s.data%0d_ack", tag, i), int'(ack), ptr_ok ? 0 : 1);
      if (ptr_ok) begin
        exp_addr.push_back(model_ptr);
        exp_data.push_back(int'(tx_data[i]));
        model_ptr = (model_ptr + 1) % NUM_REGS;
      end
    end
    bus_stop();
    checkOutput({tag, ".num_writes"}, seen_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < seen_addr.size(); i++) begin
      checkOutput($sformatf("%s.wr%0d_addr", tag, i), seen_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s.wr%0d_data", tag, i), seen_data[i], exp_data[i]);
    end
    checkOutput({tag, ".rd_addr"}, int'(o_rd_addr), model_ptr);
    checkOutput({tag, ".busy_end"}, int'(o_busy), 0);
    if (!match || ptr_ok) checkOutput({tag, ".stops"}, stop_count, match ? 1 : 0);
    if (!match) checkOutput({tag, ".sda_low"}, int'(dut_low_seen), 0);
  endtask

  // START, write pointer, repeated START, read n bytes (NACK on the last), STOP.
  task automatic applyRead(input logic [7:0] ptr_byte, input int n, input string tag);
    logic       ack;
    logic [7:0] v;
    seen_addr.delete(); seen_data.delete();
    bus_start();
    write_byte({ADDRESS, 1'b0}, ack);
    checkOutput({tag, ".addr_w_ack"}, int'(ack), 0);
    write_byte(ptr_byte, ack);
    checkOutput({tag, ".ptr_ack"}, int'(ack), 0);
    model_ptr = int'(ptr_byte);
    bus_start();
    write_byte({ADDRESS, 1'b1}, ack);
    checkOutput({tag, ".addr_r_ack"}, int'(ack), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(v, (i == n - 1));
      checkOutput($sformatf("%s.byte%0d", tag, i), int'(v), int'(rd_mem[model_ptr]));
      model_ptr = (model_ptr + 1) % NUM_REGS;
    end
    ctl_low = 1'b0;
    wait_q();
    checkOutput({tag, ".released"}, int'(sda), 1);
    bus_stop();
    checkOutput({tag, ".rd_addr"}, int'(o_rd_addr), model_ptr);
    checkOutput({tag, ".num_writes"}, seen_addr.size(), 0);
  endtask

  initial begin
    logic       ack;
    logic [6:0] a7;
    logic [7:0] p8;
    compared = 0; mismatched = 0; model_ptr = 0;
    stop_count = 0; dut_low_seen = 1'b0;
    scl = 1'b1; ctl_low = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rd_mem[i] = 8'(i * 3);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("reset.sda", int'(sda), 1);
    checkOutput("reset.wr_valid", int'(o_wr_valid), 0);
    checkOutput("reset.wr_addr", int'(o_wr_addr), 0);
    checkOutput("reset.wr_data", int'(o_wr_data), 0);
    checkOutput("reset.rd_addr", int'(o_rd_addr), 0);
    checkOutput("reset.busy", int'(o_busy), 0);
    checkOutput("reset.stop", int'(o_stop), 0);
    rst_n = 1'b1;
    wait_q();

    tx_data.delete();
    tx_data.push_back(8'h11); tx_data.push_back(8'h22); tx_data.push_back(8'h33);
    applyStimulus(8'hA0, 8'h02, "write3");

    tx_data.delete();
    tx_data.push_back(8'hAA); tx_data.push_back(8'hBB);
    applyStimulus(8'hA0, 8'h0F, "wrap");

    applyRead(8'h04, 3, "read3");

    tx_data.delete();
    tx_data.push_back(8'h5A);
    applyStimulus(8'hA2, 8'h01, "mismatch");

    tx_data.delete();
    tx_data.push_back(8'h77);
    applyStimulus(8'hA0, 8'h20, "bad_ptr");

    // Reset while the target is driving a 0 data bit.
    rd_mem[model_ptr] = 8'h3C;
    bus_start();
    write_byte({ADDRESS, 1'b1}, ack);
    checkOutput("rst.addr_ack", int'(ack), 0);
    ctl_low = 1'b0;
    wait_q();
    checkOutput("rst.driving", int'(sda), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.sda", int'(sda), 1);
    checkOutput("rst.busy", int'(o_busy), 0);
    checkOutput("rst.rd_addr", int'(o_rd_addr), 0);
    checkOutput("rst.wr_valid", int'(o_wr_valid), 0);
    checkOutput("rst.stop", int'(o_stop), 0);
    model_ptr = 0;
    scl = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q();
    tx_data.delete();
    tx_data.push_back(8'hC3);
    applyStimulus(8'hA0, 8'h07, "after_rst");

    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < NUM_REGS; i++) rd_mem[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 2) begin
        applyRead(8'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(1, 4)),
                  $sformatf("rnd%0d_rd", k));
      end else begin
        a7 = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ADDRESS;
        p8 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NUM_REGS, 255))
                                         : 8'($urandom_range(0, NUM_REGS - 1));
        tx_data.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx_data.push_back(8'($urandom));
        applyStimulus({a7, 1'b0}, p8, $sformatf("rnd%0d_wr", k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
